// File: rtl/xpar_uart_tx.sv
// xpar_uart_tx: memory-mapped 8N1 UART transmitter behind the xtop parallel bus, with an 8-entry TX FIFO.
// Latency: the start bit drives txd one clock after the push cycle; each bit lasts DIV clocks (DIV 0/1 -> 1).
// Backpressure: none on the bus; a push into a full FIFO is dropped, and firmware polls STATUS.full/empty/busy.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active low
//   par_addr  register address; only [1:0] decoded (0 DATA, 1 STATUS, 2 DIV, 3 CTRL)
//   par_we    write strobe, sampled on posedge clk
//   par_in    write data
//   par_out   read data, combinational decode of par_addr
//   txd       serial line, idle high
//   tx_irq    registered: FIFO empty and shifter idle
//
// Optional build macro XPAR_UART_PARITY_EN: adds a parity bit (CTRL bit2: 1 odd, 0 even),
// giving 11-bit frames. Without it frames are 10 bits and CTRL bit2 reads 0.

`timescale 1ns/1ps

module xpar_uart_tx #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned PADDR_W         = 8,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3,
  parameter logic [15:0] DIV_RST         = 16'd868
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PADDR_W-1:0] par_addr,
  input  logic               par_we,
  input  logic [DATA_W-1:0]  par_in,
  output logic [DATA_W-1:0]  par_out,
  output logic               txd,
  output logic               tx_irq
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W = FIFO_DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ------------------------------------------------------------------
  // Register decode
  // ------------------------------------------------------------------
  logic [1:0] reg_sel;
  logic       wr_data;
  logic       wr_div;
  logic       wr_ctrl;

  assign reg_sel = par_addr[1:0];
  assign wr_data = par_we && (reg_sel == 2'd0);
  assign wr_div  = par_we && (reg_sel == 2'd2);
  assign wr_ctrl = par_we && (reg_sel == 2'd3);

  // Bus bits that carry no register content.
  logic unused_bits;
  assign unused_bits = ^{par_addr[PADDR_W-1:2], par_in[DATA_W-1:16]};

  // ------------------------------------------------------------------
  // Configuration registers
  // ------------------------------------------------------------------
  logic [15:0] div_q;
  logic [15:0] div_d;
  logic        tx_en_q;

  assign div_d = wr_div ? par_in[15:0] : div_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q   <= DIV_RST;
      tx_en_q <= 1'b1;
    end else begin
      if (wr_div)  div_q   <= par_in[15:0];
      if (wr_ctrl) tx_en_q <= par_in[0];
    end
  end

`ifdef XPAR_UART_PARITY_EN
  logic parity_odd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_odd_q <= 1'b0;
    end else if (wr_ctrl) begin
      parity_odd_q <= par_in[2];
    end
  end
`endif

  // ------------------------------------------------------------------
  // TX FIFO
  // ------------------------------------------------------------------
  logic [7:0]                 fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wptr_q;
  logic [FIFO_DEPTH_LOG2-1:0] rptr_q;
  logic [CNT_W-1:0]           count_q;
  logic [CNT_W-1:0]           count_d;
  logic [7:0]                 fifo_rdata;
  logic                       full;
  logic                       empty;
  logic                       flush;
  logic                       push;
  logic                       pop;
  state_t                     state_q;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign flush      = wr_ctrl && par_in[1];
  // Flush wins over anything else touching the FIFO in the same cycle.
  assign push       = wr_data && !full && !flush;
  assign pop        = (state_q == S_IDLE) && !empty && tx_en_q && !flush;
  assign fifo_rdata = fifo_mem[rptr_q];

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= par_in[7:0];
  end

  // ------------------------------------------------------------------
  // Baud timing and shifter FSM
  // ------------------------------------------------------------------
  logic [15:0] cnt_q;
  logic [15:0] div_act_q;   // divisor in force for the current bit
  logic [15:0] div_eff;
  logic        bit_end;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic        txd_q;
  logic        tx_irq_q;
  logic        busy;
`ifdef XPAR_UART_PARITY_EN
  logic        par_bit_q;
`endif

  assign div_eff = (div_act_q < 16'd2) ? 16'd1 : div_act_q;
  // >= keeps a shrinking divisor from stranding the counter past its terminal value.
  assign bit_end = (cnt_q >= (div_eff - 16'd1));
  assign busy    = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      txd_q     <= 1'b1;
      tx_irq_q  <= 1'b1;
      cnt_q     <= '0;
      div_act_q <= DIV_RST;
      shift_q   <= '0;
      bit_idx_q <= '0;
`ifdef XPAR_UART_PARITY_EN
      par_bit_q <= 1'b0;
`endif
    end else begin
      tx_irq_q <= empty && (state_q == S_IDLE);

      if (state_q == S_IDLE) begin
        txd_q <= 1'b1;
        if (pop) begin
          state_q   <= S_START;
          txd_q     <= 1'b0;
          shift_q   <= fifo_rdata;
          cnt_q     <= '0;
          bit_idx_q <= '0;
          // A divisor written in this very cycle already applies to the start bit.
          div_act_q <= div_d;
`ifdef XPAR_UART_PARITY_EN
          par_bit_q <= (^fifo_rdata) ^ parity_odd_q;
`endif
        end
      end else if (!bit_end) begin
        cnt_q <= cnt_q + 16'd1;
      end else begin
        // Bit boundary: restart the count and pick up any new divisor.
        cnt_q     <= '0;
        div_act_q <= div_d;
        case (state_q)
          S_START: begin
            state_q <= S_DATA;
            txd_q   <= shift_q[0];
          end
          S_DATA: begin
            if (bit_idx_q == 3'd7) begin
`ifdef XPAR_UART_PARITY_EN
              state_q <= S_PARITY;
              txd_q   <= par_bit_q;
`else
              state_q <= S_STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              txd_q     <= shift_q[1];
            end
          end
`ifdef XPAR_UART_PARITY_EN
          S_PARITY: begin
            state_q <= S_STOP;
            txd_q   <= 1'b1;
          end
`endif
          default: begin
            // End of stop bit: one IDLE evaluation before any next frame.
            state_q <= S_IDLE;
            txd_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign txd    = txd_q;
  assign tx_irq = tx_irq_q;

  // ------------------------------------------------------------------
  // Read mux
  // ------------------------------------------------------------------
  logic [7:0] status_bits;
  logic [2:0] ctrl_bits;
  logic [3:0] count4;

  assign count4      = 4'(count_q);
  assign status_bits = {count4, 1'b0, busy, empty, full};
`ifdef XPAR_UART_PARITY_EN
  assign ctrl_bits   = {parity_odd_q, 1'b0, tx_en_q};
`else
  assign ctrl_bits   = {2'b00, tx_en_q};
`endif

  always_comb begin
    par_out = '0;
    case (reg_sel)
      2'd1:    par_out = DATA_W'(status_bits);
      2'd2:    par_out = DATA_W'(div_q);
      2'd3:    par_out = DATA_W'(ctrl_bits);
      default: par_out = '0;
    endcase
  end

endmodule

// File: tb/tb_xpar_uart_tx.sv
// tb_xpar_uart_tx: directed and randomised stimulus for xpar_uart_tx against a queue-based line model.
// The model holds accepted bytes in order and predicts each frame bit by bit from divisor and data.
// Frames are captured on the falling clock edge, away from the DUT's active edge.

`timescale 1ns/1ps

module tb_xpar_uart_tx;

`ifdef XPAR_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  par_addr = '0;
  logic        par_we = 1'b0;
  logic [31:0] par_in = '0;
  logic [31:0] par_out;
  logic        txd;
  logic        tx_irq;

  int checks = 0;
  int errors = 0;

  // Bytes accepted by the FIFO and not yet seen starting on the line.
  logic [7:0] model_q[$];
  int         model_div = 868;
  bit         model_odd = 1'b0;

  always #5 clk = ~clk;

  xpar_uart_tx dut (
    .clk      (clk),
    .rst      (rst),
    .par_addr (par_addr),
    .par_we   (par_we),
    .par_in   (par_in),
    .par_out  (par_out),
    .txd      (txd),
    .tx_irq   (tx_irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input int cnt, input bit bsy);
    logic [31:0] s;
    s = 32'(cnt) << 4;
    if (bsy)      s = s | 32'h4;
    if (cnt == 0) s = s | 32'h2;
    if (cnt == 8) s = s | 32'h1;
    return s;
  endfunction

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    par_addr = {6'b0, a};
    par_in   = d;
    par_we   = 1'b1;
    case (a)
      2'd0: if (model_q.size() < 8) model_q.push_back(d[7:0]);
      2'd2: model_div = int'(d[15:0]);
      2'd3: begin
        if (d[1]) model_q.delete();
`ifdef XPAR_UART_PARITY_EN
        model_odd = d[2];
`endif
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
    par_we = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
    par_addr = {6'b0, a};
    #1;
    d = par_out;
  endtask

  // Waits for a start bit, then checks every clock of the frame against the model.
  task automatic rx_frame(input string tag, input int max_wait, output int waited, output logic pbit);
    logic [7:0]  exp;
    logic [7:0]  got;
    logic [10:0] bits;
    int          deff;
    int          errs;
    deff   = (model_div < 2) ? 1 : model_div;
    waited = 0;
    pbit   = 1'b0;
    @(negedge clk);
    while (txd !== 1'b0 && waited < max_wait) begin
      waited++;
      @(negedge clk);
    end
    chk({tag, " start seen"}, 32'(waited < max_wait), 32'd1);
    if (waited >= max_wait) return;
    chk({tag, " frame queued"}, 32'(model_q.size() > 0), 32'd1);
    exp = (model_q.size() > 0) ? model_q.pop_front() : 8'h00;
    bits = '1;
    bits[0]   = 1'b0;
    bits[8:1] = exp;
`ifdef XPAR_UART_PARITY_EN
    bits[9]   = (^exp) ^ model_odd;
`endif
    errs = 0;
    got  = '0;
    for (int i = 0; i < NBITS; i++) begin
      for (int c = 0; c < deff; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        if (txd !== bits[i]) errs++;
        if (c == deff / 2) begin
          if (i >= 1 && i <= 8) got[i-1] = txd;
          if (i == 9) pbit = txd;
        end
      end
    end
    chk({tag, " data"}, 32'(got), 32'(exp));
    chk({tag, " waveform errs"}, 32'(errs), 32'd0);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk({tag, " line quiet"}, 32'(lows), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          w;
    int          w2;
    logic        pb;
    int          n;
    int          dv;

    // ---- reset ----
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reg_rd(2'd1, rd);
    chk("in-reset status", rd, 32'h2);
    chk("in-reset txd", 32'(txd), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    reg_rd(2'd1, rd); chk("reset status", rd, exp_status(0, 0));
    reg_rd(2'd2, rd); chk("reset div", rd, 32'd868);
    reg_rd(2'd3, rd); chk("reset ctrl", rd, 32'h1);
    reg_rd(2'd0, rd); chk("data read", rd, 32'h0);
    chk("reset txd", 32'(txd), 32'd1);
    chk("reset irq", 32'(tx_irq), 32'd1);

    // ---- single frame, DIV=4 ----
    reg_wr(2'd2, 32'd4);
    reg_wr(2'd0, 32'h55);
    rx_frame("b55", 20, w, pb);
    chk("b55 latency", 32'(w), 32'd1);
    repeat (3) @(negedge clk);
    chk("b55 irq", 32'(tx_irq), 32'd1);
    reg_rd(2'd1, rd); chk("b55 status", rd, exp_status(model_q.size(), 0));

    // ---- fill while disabled, overflow dropped ----
    reg_wr(2'd2, 32'd2);
    reg_wr(2'd3, 32'h0);
    for (int i = 0; i < 9; i++) reg_wr(2'd0, 32'(i));
    repeat (4) @(negedge clk);
    reg_rd(2'd1, rd); chk("full status", rd, exp_status(model_q.size(), 0));
    chk("full status literal", rd, 32'h81);
    chk("disabled txd", 32'(txd), 32'd1);
    reg_wr(2'd3, 32'h1);
    for (int i = 0; i < 8; i++) begin
      rx_frame("burst", 30, w, pb);
      chk("burst gap", 32'(w), 32'd1);
    end
    expect_quiet("after burst", 60);
    reg_rd(2'd1, rd); chk("burst end status", rd, exp_status(0, 0));

    // ---- flush during first frame ----
    reg_wr(2'd2, 32'd10);
    fork
      begin
        reg_wr(2'd0, 32'hC3);
        reg_wr(2'd0, 32'h3C);
        reg_wr(2'd0, 32'h99);
        repeat (20) @(posedge clk);
        #1;
        reg_rd(2'd1, rd); chk("pre-flush status", rd, exp_status(model_q.size(), 1));
        reg_wr(2'd3, 32'h3);
        reg_rd(2'd1, rd); chk("post-flush status", rd, exp_status(0, 1));
      end
      rx_frame("flush", 20, w2, pb);
    join
    expect_quiet("after flush", 150);
    chk("flush irq", 32'(tx_irq), 32'd1);
    reg_rd(2'd3, rd); chk("flush self-clear", rd, 32'h1);

    // ---- reset in the middle of a data bit ----
    reg_wr(2'd2, 32'd8);
    reg_wr(2'd0, 32'hF0);
    repeat (29) @(negedge clk);
    reg_rd(2'd1, rd); chk("mid-frame status", rd, exp_status(0, 1));
    chk("mid-frame txd", 32'(txd), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("abort txd", 32'(txd), 32'd1);
    chk("abort irq", 32'(tx_irq), 32'd1);
    reg_rd(2'd1, rd); chk("abort status", rd, 32'h2);
    reg_rd(2'd2, rd); chk("abort div", rd, 32'd868);
    model_q.delete();
    model_div = 868;
    model_odd = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    reg_wr(2'd2, 32'd3);
    reg_wr(2'd0, 32'hA3);
    rx_frame("post-reset", 20, w, pb);
    chk("post-reset latency", 32'(w), 32'd1);

    // ---- DIV=0 behaves as one clock per bit ----
    reg_wr(2'd2, 32'd0);
    reg_wr(2'd0, 32'h6E);
    rx_frame("div0", 20, w, pb);
    chk("div0 latency", 32'(w), 32'd1);

    // ---- randomised bursts ----
    for (int it = 0; it < 5; it++) begin
      n  = int'($urandom_range(1, 8));
      dv = int'($urandom_range(0, 5));
      reg_wr(2'd2, 32'(dv));
      fork
        for (int k = 0; k < n; k++) reg_wr(2'd0, $urandom_range(0, 255));
        for (int k = 0; k < n; k++) begin
          rx_frame("rand", 40, w2, pb);
          if (k > 0) chk("rand gap", 32'(w2), 32'd1);
        end
      join
      repeat (4) @(negedge clk);
      reg_rd(2'd1, rd); chk("rand status", rd, exp_status(model_q.size(), 0));
      chk("rand irq", 32'(tx_irq), 32'd1);
    end

    // ---- parity / CTRL bit2 ----
`ifdef XPAR_UART_PARITY_EN
    reg_wr(2'd2, 32'd3);
    reg_wr(2'd3, 32'h1);
    reg_wr(2'd0, 32'h07);
    rx_frame("even", 20, w, pb);
    chk("even parity bit", 32'(pb), 32'd1);
    reg_wr(2'd3, 32'h5);
    reg_rd(2'd3, rd); chk("ctrl odd readback", rd, 32'h5);
    reg_wr(2'd0, 32'h07);
    rx_frame("odd", 20, w, pb);
    chk("odd parity bit", 32'(pb), 32'd0);
    chk("odd latency", 32'(w), 32'd1);
`else
    reg_wr(2'd3, 32'h5);
    reg_rd(2'd3, rd); chk("ctrl bit2 ignored", rd, 32'h1);
    reg_wr(2'd2, 32'd2);
    reg_wr(2'd0, 32'h07);
    rx_frame("noparity", 20, w, pb);
    chk("noparity latency", 32'(w), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xpar_uart_tx.md
Name: xpar_uart_tx

Overview:
- Memory-mapped UART transmitter that sits directly downstream of xtop's external parallel interface (par_addr/par_we/par_in/par_out).
- The picoVersat program writes bytes into an 8-entry TX FIFO.
- The block serialises each byte as 8N1 on a single line at a programmable baud rate.
- Status is readable back through par_out, so firmware can poll for full/empty/busy.

Parameters:
- DATA_W, 32, parallel data width; matches `DATA_W.
- PADDR_W, 8, width of par_addr; matches `ADDR_W-1.
- FIFO_DEPTH_LOG2, 3, log2 of TX FIFO depth (8 entries).
- DIV_RST, 16'd868, baud divisor reset value (100 MHz / 115200).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- par_addr  in  PADDR_W  register address; only bits [1:0] decoded.
- par_we  in  1  write strobe, sampled on posedge clk.
- par_in  in  DATA_W  write data.
- par_out  out  DATA_W  read data, combinational from par_addr.
- txd  out  1  serial output, idle high.
- tx_irq  out  1  high while FIFO is empty and the shifter is idle.

Behaviour:
Register map (par_addr[1:0]):
- 0 DATA: a write pushes par_in[7:0]; reads return 0.
- 1 STATUS: bit0 full, bit1 empty, bit2 busy (shifter active), bits[7:4] FIFO count (0-8), other bits 0.
- 2 DIV: read/write baud divisor in bits[15:0].
- 3 CTRL: bit0 tx_en. When tx_en=0, the shifter does not pop the FIFO. A write with bit1=1 flushes the FIFO (self-clearing).

Reset (rst=0, asynchronous):
- FIFO empty, count=0, DIV=DIV_RST, tx_en=1.
- State IDLE, txd=1, tx_irq=1, baud counter 0.
- par_out still follows the combinational decode (STATUS reads 0x02).
- Reset asserted mid-frame aborts the frame. txd returns to 1 asynchronously.

FIFO:
- Write pointer, read pointer and count are registered.
- Push when par_we && addr==0 && !full. A push while full is dropped silently; count and contents are unchanged.
- Pop happens only in IDLE->START when count>0 and tx_en=1.
- Simultaneous push and pop leave count unchanged, and both pointers advance.
- Pointers wrap modulo 8.
- Flush takes priority over a push in the same cycle: pointers are reset and count=0. It does not affect a frame already in the shifter.

Baud:
- A 16-bit counter counts 0..DIV-1, and each bit lasts DIV clocks.
- DIV=0 or DIV=1 is treated as 1 (one clock per bit).
- A DIV write takes effect at the next bit boundary.

State machine:
- IDLE: txd=1. If count>0 and tx_en, pop into the shift register, reset the baud counter, go to START.
- START: txd=0 for one bit time, then DATA.
- DATA: txd=shift[0], LSB first. Shift right each bit time. After 8 bits go to STOP (PARITY if enabled).
- STOP: txd=1 for one bit time, then IDLE.

Timing and outputs:
- The first start bit appears on txd 1 clock after the push cycle (registered pop).
- Back-to-back frames: the next START follows STOP directly, with 1 idle clock from the IDLE evaluation.
- busy=1 in every state except IDLE.
- tx_irq = empty && !busy, registered.
- Clearing tx_en mid-frame completes the current frame, then the block holds in IDLE.

Optional Feature:
- Macro XPAR_UART_PARITY_EN.
- When defined:
  - CTRL bit2 selects odd parity (1) or even parity (0), reset 0.
  - A PARITY state is inserted between DATA and STOP, transmitting the XOR of the 8 data bits (inverted for odd).
  - Frame length is 11 bit times.
- When undefined:
  - No PARITY state; frames are 10 bit times.
  - CTRL bit2 reads 0 and writes to it are ignored.

Test Plan:
- Reset, then read STATUS -> par_out=0x00000002, txd=1, tx_irq=1, DIV reads 868.
- DIV=4, write DATA=0x55 -> txd low 1 clock after push for 4 clocks; then 1,0,1,0,1,0,1,0 at 4 clocks each; then high 4 clocks; tx_irq returns to 1.
- DIV=2, tx_en=0, write 9 bytes 0x00..0x08 -> STATUS count=8, full=1, 9th dropped. Set tx_en=1 -> exactly 0x00..0x07 transmitted in order.
- Write 3 bytes with DIV=10, flush during the first frame -> first frame completes, count=0, nothing further sent.
- Assert rst mid DATA bit -> txd=1 immediately, FIFO empty, next frame after release starts cleanly.
- With XPAR_UART_PARITY_EN, CTRL=0x1 (even), DATA=0x07 -> parity bit=1; CTRL=0x5 (odd) -> parity bit=0; frame is 11 bit times.
